// File: rtl/tod_read_latch_if.sv
// Bus-side signal bundle for the TOD read latch: live TOD in, read strobe/select in,
// read data and freeze flag out.
interface tod_read_latch_if;
    logic [31:0] tod_in;
    logic        rd;
    logic [1:0]  addr;
    logic [7:0]  dout;
    logic        latched;

    modport master (
        output tod_in,
        output rd,
        output addr,
        input  dout,
        input  latched
    );

    modport slave (
        input  tod_in,
        input  rd,
        input  addr,
        output dout,
        output latched
    );
endinterface

// File: rtl/tod_read_latch.sv
// TOD read front end: a read of the top TOD register freezes a coherent snapshot,
// and a read of the bottom register releases it.
module tod_read_latch #(
    parameter int MODEL = 0
) (
    input  logic              clk,
    input  logic              rst,
    tod_read_latch_if.slave   bus
);
    typedef enum logic {FREE, LATCHED} state_t;

    localparam logic [1:0] LA = (MODEL == 1) ? 2'd2 : 2'd3;
    localparam logic [1:0] RA = 2'd0;

    state_t      state;
    logic [31:0] snapshot;
    logic [31:0] src;

    function automatic logic [7:0] read_byte(input logic [31:0] v, input logic [1:0] a);
        logic [7:0] b;
        b = v[{a, 3'b000} +: 8];
        if (MODEL == 1) begin
            read_byte = (a == 2'd3) ? '0 : b;
        end else begin
            case (a)
                2'd0:    read_byte = b & 8'h0F;
                2'd1:    read_byte = b & 8'h7F;
                2'd2:    read_byte = b & 8'h7F;
                default: read_byte = b & 8'h9F;
            endcase
        end
    endfunction

    assign src = (state == LATCHED) ? snapshot : bus.tod_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FREE;
            snapshot    <= '0;
            bus.dout    <= '0;
            bus.latched <= 1'b0;
        end else begin
            // Snapshot tracks the live value while free, so the LA read and the
            // frozen bytes come from the same sampled tod_in.
            if (state == FREE) begin
                snapshot <= bus.tod_in;
            end
            if (bus.rd) begin
                bus.dout <= read_byte(src, bus.addr);
                case (state)
                    FREE: begin
                        if (bus.addr == LA) begin
                            state       <= LATCHED;
                            bus.latched <= 1'b1;
                        end
                    end
                    LATCHED: begin
                        if (bus.addr == RA) begin
                            state       <= FREE;
                            bus.latched <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= FREE;
                        bus.latched <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tod_read_latch.sv
// Scoreboard bench for tod_read_latch: directed reads push expected bytes,
// a negedge monitor pops and compares one cycle after each strobe.
module tb_tod_read_latch;
    logic clk;
    logic rst;

    tod_read_latch_if bus0 ();
    tod_read_latch_if bus1 ();

    tod_read_latch #(.MODEL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    tod_read_latch #(.MODEL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        bit         which;
        logic [7:0] d;
        logic       l;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    logic rd0_d, rd1_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd0_d <= bus0.rd;
        rd1_d <= bus1.rd;
    end

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Monitor: compares each DUT response against the oldest queued expectation.
    always @(negedge clk) begin
        if (rd0_d || rd1_d) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got response expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.which == 1'b0) begin
                    check8({e.nm, "_dout"}, bus0.dout, e.d);
                    check1({e.nm, "_lat"}, bus0.latched, e.l);
                end else begin
                    check8({e.nm, "_dout"}, bus1.dout, e.d);
                    check1({e.nm, "_lat"}, bus1.latched, e.l);
                end
            end
        end
    end

    task automatic rd_op(input bit which, input logic [1:0] a, input logic [7:0] d,
                         input logic l, input string nm);
        exp_t e;
        @(negedge clk);
        if (which == 1'b0) begin bus0.rd = 1'b1; bus0.addr = a; end
        else               begin bus1.rd = 1'b1; bus1.addr = a; end
        e.which = which; e.d = d; e.l = l; e.nm = nm;
        sb.push_back(e);
        @(negedge clk);
        bus0.rd = 1'b0;
        bus1.rd = 1'b0;
    endtask

    task automatic set_tod(input bit which, input logic [31:0] v);
        @(negedge clk);
        if (which == 1'b0) bus0.tod_in = v;
        else               bus1.tod_in = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        bus0.rd = 1'b0; bus0.addr = 2'd0; bus0.tod_in = '0;
        bus1.rd = 1'b0; bus1.addr = 2'd0; bus1.tod_in = '0;
        repeat (3) @(negedge clk);
        check8("rst0_dout", bus0.dout, 8'h00);
        check1("rst0_lat", bus0.latched, 1'b0);
        check8("rst1_dout", bus1.dout, 8'h00);
        check1("rst1_lat", bus1.latched, 1'b0);
        rst = 1'b0;

        // MODEL 0 basic live read then latch
        set_tod(0, 32'h9259_5909);
        rd_op(0, 2'd0, 8'h09, 1'b0, "m0_live_a0");
        rd_op(0, 2'd3, 8'h92, 1'b1, "m0_latch_a3");
        rd_op(0, 2'd0, 8'h09, 1'b0, "m0_rel_a0");

        // Latch across a rollover
        set_tod(0, 32'h1159_5909);
        rd_op(0, 2'd3, 8'h11, 1'b1, "roll_a3");
        set_tod(0, 32'h1200_0000);
        rd_op(0, 2'd2, 8'h59, 1'b1, "roll_a2");
        rd_op(0, 2'd1, 8'h59, 1'b1, "roll_a1");
        rd_op(0, 2'd0, 8'h09, 1'b0, "roll_a0");
        rd_op(0, 2'd3, 8'h12, 1'b1, "roll_next_a3");
        rd_op(0, 2'd0, 8'h00, 1'b0, "roll_next_a0");

        // Repeated LA read while latched: no re-capture
        set_tod(0, 32'h0830_1504);
        rd_op(0, 2'd3, 8'h08, 1'b1, "rep_a3_1");
        set_tod(0, 32'h0931_0000);
        rd_op(0, 2'd3, 8'h08, 1'b1, "rep_a3_2");
        rd_op(0, 2'd3, 8'h08, 1'b1, "rep_a3_3");
        rd_op(0, 2'd0, 8'h04, 1'b0, "rep_a0");

        // dout holds while rd is idle
        repeat (3) @(negedge clk);
        check8("hold_dout", bus0.dout, 8'h04);

        // Masks on all-ones input
        set_tod(0, 32'hFFFF_FFFF);
        rd_op(0, 2'd0, 8'h0F, 1'b0, "mask_a0");
        rd_op(0, 2'd1, 8'h7F, 1'b0, "mask_a1");
        rd_op(0, 2'd2, 8'h7F, 1'b0, "mask_a2");
        rd_op(0, 2'd3, 8'h9F, 1'b1, "mask_a3");
        rd_op(0, 2'd0, 8'h0F, 1'b0, "mask_rel");

        // Invalid BCD passes through
        set_tod(0, 32'h0000_000C);
        rd_op(0, 2'd0, 8'h0C, 1'b0, "badbcd_a0");

        // MODEL 1 binary layout
        set_tod(1, 32'h00AB_CDEF);
        rd_op(1, 2'd3, 8'h00, 1'b0, "m1_free_a3");
        rd_op(1, 2'd2, 8'hAB, 1'b1, "m1_latch_a2");
        set_tod(1, 32'h00AB_CE00);
        rd_op(1, 2'd1, 8'hCD, 1'b1, "m1_a1");
        rd_op(1, 2'd3, 8'h00, 1'b1, "m1_lat_a3");
        rd_op(1, 2'd0, 8'hEF, 1'b0, "m1_rel_a0");
        set_tod(1, 32'hFF12_3456);
        rd_op(1, 2'd2, 8'h12, 1'b1, "m1_hi_a2");
        rd_op(1, 2'd0, 8'h56, 1'b0, "m1_hi_a0");

        // Asynchronous reset while latched
        set_tod(0, 32'h0102_0304);
        rd_op(0, 2'd3, 8'h01, 1'b1, "ar_a3");
        set_tod(1, 32'h0011_2233);
        rd_op(1, 2'd2, 8'h11, 1'b1, "ar1_a2");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("ar_lat0", bus0.latched, 1'b0);
        check8("ar_dout0", bus0.dout, 8'h00);
        check1("ar_lat1", bus1.latched, 1'b0);
        check8("ar_dout1", bus1.dout, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bus0.tod_in = 32'h1122_3344;
        bus1.tod_in = 32'h0077_8899;
        rd_op(0, 2'd1, 8'h33, 1'b0, "ar_live_a1");
        rd_op(1, 2'd1, 8'h88, 1'b0, "ar1_live_a1");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
